// File: rtl/cliff_seg_display_if.sv
// Load/status channel between the cliff game core and the display stage.
// The core drives score, load strobe and lose flag; the display reports busy/done.
interface cliff_seg_display_if;
    logic [13:0] value;
    logic        load;
    logic        lose;
    logic        busy;
    logic        done;

    modport master (
        output value,
        output load,
        output lose,
        input  busy,
        input  done
    );

    modport slave (
        input  value,
        input  load,
        input  lose,
        output busy,
        output done
    );
endinterface

// File: rtl/cliff_seg_display.sv
// Four-digit seven-segment stage: sequential shift-add-3 BCD conversion of a score.
// The digits are time-multiplexed onto active-low pins. CLIFF_SEG_BLANK_LZ_EN blanks leading zeros.
module cliff_seg_display #(
    parameter logic [31:0] SCAN_DIV = 32'h20000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    cliff_seg_display_if.slave        bus,
    output logic [6:0]                seg,
    output logic [3:0]                an,
    output logic                      dp
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [29:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_next_q, ovf_next_d;
    logic        ovf_q, ovf_d;
    logic [15:0] dig_q, dig_d;
    logic        done_q, done_d;
    logic [31:0] scan_q, scan_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        dp_q, dp_d;

    logic [15:0] adj;
    logic [3:0]  cur;
    logic        blank;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // Conversion FSM: capture, 14 shift-add-3 steps, then commit digits.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        ovf_d      = ovf_q;
        dig_d      = dig_q;
        done_d     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adj[i*4 +: 4] = (sr_q[14 + i*4 +: 4] >= 4'd5)
                          ? sr_q[14 + i*4 +: 4] + 4'd3
                          : sr_q[14 + i*4 +: 4];
        end
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    sr_d       = {16'd0, (bus.value > 14'd9999) ? 14'd9999 : bus.value};
                    ovf_next_d = bus.value > 14'd9999;
                    cnt_d      = 4'd14;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {adj, sr_q[13:0]} << 1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = COMMIT;
            end
            COMMIT: begin
                dig_d   = sr_q[29:14];
                ovf_d   = ovf_next_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan counter and digit index.
    always_comb begin
        scan_d = scan_q - 32'd1;
        idx_d  = idx_q;
        if (scan_q == 32'd0) begin
            scan_d = SCAN_DIV - 32'd1;
            idx_d  = idx_q + 2'd1;
        end
    end

    // Registered pin decode for the current digit slot.
    always_comb begin
        cur   = dig_q[{idx_q, 2'b00} +: 4];
        blank = 1'b0;
`ifdef CLIFF_SEG_BLANK_LZ_EN
        case (idx_q)
            2'd3:    blank = (dig_q[15:12] == 4'd0);
            2'd2:    blank = (dig_q[15:8] == 8'd0);
            2'd1:    blank = (dig_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        an_d = ~(4'b0001 << idx_q);
        if (bus.lose) begin
            dp_d = 1'b1;
            case (idx_q)
                2'd3:    seg_d = 7'b1000111;
                2'd2:    seg_d = 7'b1000000;
                2'd1:    seg_d = 7'b0010010;
                default: seg_d = 7'b0000110;
            endcase
        end else begin
            seg_d = blank ? 7'b1111111 : seg_of(cur);
            dp_d  = !((idx_q == 2'd0) && ovf_q);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            ovf_q      <= 1'b0;
            dig_q      <= '0;
            done_q     <= 1'b0;
            scan_q     <= SCAN_DIV - 32'd1;
            idx_q      <= '0;
            seg_q      <= 7'h7F;
            an_q       <= 4'hF;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            ovf_q      <= ovf_d;
            dig_q      <= dig_d;
            done_q     <= done_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_cliff_seg_display.sv
// Randomized self-checking bench for cliff_seg_display.
// Expected display derived from decimal arithmetic on the loaded score.
module tb_cliff_seg_display;
    localparam int SD = 4;
`ifdef CLIFF_SEG_BLANK_LZ_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    int         checks = 0;
    int         failures = 0;
    int         m_val = 0;
    bit         m_ovf = 1'b0;
    int         pw[4] = '{1, 10, 100, 1000};
    logic [3:0] pat[4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    cliff_seg_display_if bus();

    cliff_seg_display #(.SCAN_DIV(32'd4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .seg(seg),
        .an(an),
        .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(int d);
        case (d)
            0: glyph = 7'h40;
            1: glyph = 7'h79;
            2: glyph = 7'h24;
            3: glyph = 7'h30;
            4: glyph = 7'h19;
            5: glyph = 7'h12;
            6: glyph = 7'h02;
            7: glyph = 7'h78;
            8: glyph = 7'h00;
            default: glyph = 7'h10;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int pos);
        if (bus.lose) begin
            case (pos)
                3: exp_seg = 7'h47;
                2: exp_seg = 7'h40;
                1: exp_seg = 7'h12;
                default: exp_seg = 7'h06;
            endcase
        end else if (BLANK && pos > 0 && m_val < pw[pos]) begin
            exp_seg = 7'h7F;
        end else begin
            exp_seg = glyph((m_val / pw[pos]) % 10);
        end
    endfunction

    function automatic int pos_of(logic [3:0] a);
        case (a)
            4'hE: pos_of = 0;
            4'hD: pos_of = 1;
            4'hB: pos_of = 2;
            4'h7: pos_of = 3;
            default: pos_of = -1;
        endcase
    endfunction

    task automatic do_load(int v);
        int lat;
        @(negedge clk);
        bus.value = v[13:0];
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
        check("busy_after_load", bus.busy, 1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check("done_latency", lat, 15);
        check("busy_after_commit", bus.busy, 0);
        m_val = (v > 9999) ? 9999 : v;
        m_ovf = (v > 9999);
    endtask

    task automatic check_display(string tag);
        int cnt[4];
        int p;
        cnt = '{0, 0, 0, 0};
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4 * SD; i++) begin
            @(negedge clk);
            p = pos_of(an);
            check({tag, "_an"}, p >= 0, 1);
            if (p >= 0) begin
                cnt[p]++;
                check({tag, "_seg"}, seg, exp_seg(p));
                check({tag, "_dp"}, dp, (p == 0 && m_ovf && !bus.lose) ? 0 : 1);
            end
        end
        for (int q = 0; q < 4; q++) check({tag, "_dwell"}, cnt[q], SD);
    endtask

    initial begin
        int seen;
        int first;
        int v;
        bus.value = '0;
        bus.load = 1'b0;
        bus.lose = 1'b0;
        #23;
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_dp", dp, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("scan_an", an, pat[(k - 1) / 4]);
            check("scan_seg", seg, exp_seg((k - 1) / 4));
        end

        do_load(1234);
        check_display("n1234");
        @(negedge clk) bus.lose = 1'b1;
        check_display("lose");
        @(negedge clk) bus.lose = 1'b0;
        check_display("unlose");

        do_load(12000);
        check_display("sat");
        do_load(5);
        check_display("five");

        @(negedge clk);
        bus.value = 14'd42;
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.value = 14'd77;
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
        seen = 0;
        first = 0;
        for (int k = 6; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen++;
                if (first == 0) first = k;
            end
        end
        check("busy_drop_count", seen, 1);
        check("busy_drop_edge", first, 15);
        m_val = 42;
        m_ovf = 1'b0;
        check_display("n42");

        for (int r = 0; r < 10; r++) begin
            case ($urandom_range(0, 4))
                0: v = 9999;
                1: v = 10000;
                2: v = $urandom_range(0, 99);
                default: v = $urandom_range(0, 16383);
            endcase
            @(negedge clk) bus.lose = $urandom_range(0, 1) == 1;
            do_load(v);
            check_display("rand");
            if (bus.lose) begin
                @(negedge clk) bus.lose = 1'b0;
                check_display("rand_unlose");
            end
        end

        @(negedge clk);
        bus.value = 14'd9999;
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_seg", seg, 7'h7F);
        check("mid_rst_an", an, 4'hF);
        check("mid_rst_dp", dp, 1);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        m_val = 0;
        m_ovf = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("mid_rst_no_done", seen, 0);
        check_display("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cliff_seg_display.md
# cliff_seg_display

Four-digit seven-segment display stage sitting directly downstream of the cliff game core. It accepts a 14-bit binary score on a load strobe, converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes the four digits onto the board's active-low `seg`/`an`/`dp` pins. A lose flag overrides the numeric display with the message "LOSE".

## Interface
- `SCAN_DIV`, default `32'h20000`: clk cycles per digit slot; legal range 1 to 2^32-1.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `value` input 14: binary score, sampled only on an accepted load.
- `load` input 1: single-cycle request to convert `value`.
- `lose` input 1: level input; while 1, the display shows "LOSE".
- `busy` output 1: conversion in progress; loads are ignored while it is high.
- `done` output 1: one-cycle pulse when new digits are committed.
- `seg` output 7: active-low segments; `seg[0]`=a … `seg[6]`=g.
- `an` output 4: active-low digit enables; `an[0]` is the rightmost digit.
- `dp` output 1: active-low decimal point.

## Operation
- **Reset values:** `seg`=7'h7F, `an`=4'hF, `dp`=1, `busy`=0, `done`=0.
  - Display digits are 0, the overflow flag is 0, the scan index is 0 and the scan counter is `SCAN_DIV-1`.
- **Conversion FSM states:** IDLE, SHIFT, COMMIT.
  - **IDLE:** `load`=1 is accepted.
    - Capture `value` into the shift register, saturated: values above 9999 become 9999.
    - Set `ovf_next` = (`value` > 9999).
    - Clear the BCD accumulator, load iteration count 14, go to SHIFT.
  - **SHIFT:** each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1 and decrement the count. At count 0, go to COMMIT.
  - **COMMIT:** copy the 4 BCD nibbles into the display digit registers and `ovf_next` into `ovf`. Pulse `done`, go to IDLE.
- `busy` = (state != IDLE).
- A `load` received while `busy` is dropped, with no queueing.
- The digit registers hold their old contents throughout a conversion, so nothing flickers.
- **Scan:**
  - The counter decrements every cycle.
  - When it reaches 0 it reloads `SCAN_DIV-1` and the index advances 0→1→2→3→0.
  - `an` = ~(4'b0001 << index) whenever reset is released.
- **Segment decode, digits 0–9 (`seg[6:0]`):**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Blank = 1111111.
- **Lose message:** while `lose`=1, index 3..0 shows L (1000111), O (1000000), 5 (0010010), E (0000110). `dp`=1 in this mode. The override takes effect on the next cycle and does not affect conversion.
- **`dp`:** 0 only when index=0, `ovf`=1 and `lose`=0. Otherwise 1.

## Timing
- `load` accepted at edge N:
  - `busy`=1 after edge N.
  - SHIFT occupies edges N+1..N+14.
  - COMMIT is at edge N+15: `done`=1 and new digits are visible, both registered outputs.
  - `busy`=0 after edge N+15.
  - A new load is accepted at edge N+16 at the earliest.
- `seg`, `an` and `dp` are registered, one cycle behind the index/digit state.
- With `SCAN_DIV`=1, the index advances every cycle.
- If reset asserts mid-conversion, all state returns to reset values immediately. The partial result is discarded and no `done` is issued.

## Configuration
- `CLIFF_SEG_BLANK_LZ_EN`
  - **Defined:** leading zeros are blanked.
    - Digit k (k=3,2,1) shows blank when it and all higher digits are 0.
    - Digit 0 is always shown.
    - Blanking applies to numeric mode only, not to the LOSE message.
  - **Undefined:** all four digits are always shown; for example, 7 displays as "0007".

## Test plan
- **Reset:** hold `reset_n`=0 → `seg`=7F, `an`=F, `dp`=1, `busy`=0. After release with `SCAN_DIV`=4, `an` cycles E,D,B,7 every 4 cycles, showing "0" or blank according to the macro.
- **Normal load:** `load` with `value`=1234 at edge N → `done`=1 exactly at N+15. `an`=E shows 0011001 (4) and `an`=7 shows 1111001 (1). `dp`=1 throughout.
- **Saturation:** `value`=12000 → digits are 9999. `dp`=0 only while `an`=E. A later load of 5 clears `dp`, and with the macro defined digits 3..1 are blank.
- **Load while busy:** loads of 42, then 77 at N+5 → 77 is ignored and a single `done` at N+15 shows 0042 (or "42" blanked).
- **Reset mid-operation:** `reset_n` low at N+7 during a conversion of 9999 → no `done`; digits read 0 after release.
- **Lose override:** `lose`=1 → `an`=7/B/D/E show 1000111/1000000/0010010/0000110 and `dp`=1. Dropping `lose` restores the previous number.
